// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake bundle for uart_rx
interface uart_rx_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  // Receiver side drives the byte and its valid flag.
  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready
  );

  // Consumer side accepts the byte.
  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready byte output
module uart_rx #(
  parameter int CYCLES_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  uart_rx_if.master   rx,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam logic [15:0] HALF_LAST = 16'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        rxd_m, rxd_s;
  logic        done, ferr;
  logic        xfer;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_m <= 1'b0;
      rxd_s <= 1'b0;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  // Frame FSM registers: state, bit-period counter, bit index, shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_HIGH;
      cnt   <= 16'd0;
      idx   <= 3'd0;
      shreg <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  // Next-state logic; samples are taken mid-bit after a half-period start check.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    done    = 1'b0;
    ferr    = 1'b0;
    case (state)
      WAIT_HIGH: begin
        if (rxd_s) state_n = IDLE;
      end
      IDLE: begin
        if (!rxd_s) begin
          state_n = START;
          cnt_n   = 16'd0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = 16'd0;
          if (!rxd_s) begin
            state_n = DATA;
            idx_n   = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          shreg_n[idx] = rxd_s;
          cnt_n        = 16'd0;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = 16'd0;
          if (rxd_s) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = WAIT_HIGH;
    endcase
  end

  assign busy = (state == START) || (state == DATA) || (state == STOP);
  assign xfer = rx.rx_valid && rx.rx_ready;

  // Output holding register: load on free slot or same-cycle transfer, else flag overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx.rx_valid <= 1'b0;
      rx.rx_data  <= 8'd0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= 1'b0;
      if (done) begin
        if (!rx.rx_valid || xfer) begin
          rx.rx_data  <= shreg;
          rx.rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;
  localparam int CPB = 16;
  // Line-in to valid-out: 2 sync flops + IDLE detect + half bit + 9 full bits.
  localparam int LATENCY = 2 + 1 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic uart_rxd;
  logic frame_err;
  logic overrun;
  logic busy;
  logic ready_mode;
  logic ready_const;
  logic valid_d = 1'b0;

  uart_rx_if rx();

  assign rx.rx_ready = ready_mode ? valid_d : ready_const;

  uart_rx #(.CYCLES_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .rx        (rx),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cycle = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cycles = 0;
  int busy_cycles = 0;
  int rise_cycle = -1;
  int viol = 0;
  logic prev_valid = 1'b0;
  logic prev_xfer = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] got_q[$];

  // Observe the DUT each edge: transfers, flag pulses, and data stability.
  always @(posedge clk) begin
    cycle   <= cycle + 1;
    valid_d <= rx.rx_valid;
    if (!reset) begin
      if (rx.rx_valid && rx.rx_ready) got_q.push_back(rx.rx_data);
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (rx.rx_valid) valid_cycles <= valid_cycles + 1;
      if (rx.rx_valid && !prev_valid) rise_cycle <= cycle;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (prev_valid && !prev_xfer && (!rx.rx_valid || rx.rx_data !== prev_data))
        viol <= viol + 1;
    end
    prev_valid <= rx.rx_valid;
    prev_xfer  <= rx.rx_valid && rx.rx_ready;
    prev_data  <= rx.rx_data;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n);
    uart_rxd = v;
    wait_cycles(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop_val, CPB * stop_len);
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    uart_rxd = 1'b1;
    wait_cycles(3);
    checks++; if (rx.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx.rx_valid); end
    checks++; if (rx.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx.rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    wait_cycles(4);
  endtask

  task automatic test_single;
    int c0, vc0, fe0, ov0;
    ready_const = 1'b1;
    got_q.delete();
    vc0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
    c0 = cycle;
    send_frame(8'hA5, 1'b1, 1);
    wait_cycles(20);
    checks++; if (rise_cycle - c0 !== LATENCY) begin errors++; $display("FAIL single_latency: got %0d expected %0d", rise_cycle - c0, LATENCY); end
    checks++; if (valid_cycles - vc0 !== 1) begin errors++; $display("FAIL single_valid_width: got %0d expected 1", valid_cycles - vc0); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", got_q[0]); end
    end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL single_frame_err: got %0d expected 0", fe_cnt - fe0); end
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL single_overrun: got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_glitch;
    int b0, vc0, fe0, ov0;
    ready_const = 1'b1;
    b0 = busy_cycles; vc0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
    drive(1'b0, 3);
    drive(1'b1, 2 * CPB);
    checks++; if (busy_cycles - b0 !== CPB / 2) begin errors++; $display("FAIL glitch_busy_cycles: got %0d expected %0d", busy_cycles - b0, CPB / 2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    checks++; if (valid_cycles - vc0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", valid_cycles - vc0); end
    checks++; if ((fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin errors++; $display("FAIL glitch_flags: got %0d expected 0", (fe_cnt - fe0) + (ov_cnt - ov0)); end
  endtask

  task automatic test_frame_err;
    int vc0, fe0, ov0;
    ready_const = 1'b1;
    got_q.delete();
    vc0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 2);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (valid_cycles - vc0 !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 0", valid_cycles - vc0); end
    drive(1'b1, 2 * CPB);
    send_frame(8'h81, 1'b1, 1);
    wait_cycles(CPB);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h expected 81", got_q[0]); end
    end
    checks++; if (rx.rx_data !== 8'h81) begin errors++; $display("FAIL ferr_rx_data: got %h expected 81", rx.rx_data); end
    checks++; if (fe_cnt - fe0 !== 1 || ov_cnt - ov0 !== 0) begin errors++; $display("FAIL ferr_flags: got fe=%0d ov=%0d expected fe=1 ov=0", fe_cnt - fe0, ov_cnt - ov0); end
  endtask

  task automatic test_overrun;
    int ov0;
    ready_const = 1'b0;
    got_q.delete();
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    wait_cycles(CPB);
    checks++; if (rx.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", rx.rx_valid); end
    checks++; if (rx.rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data_kept: got %h expected 11", rx.rx_data); end
    checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d expected 1", ov_cnt - ov0); end
    ready_const = 1'b1;
    wait_cycles(1);
    ready_const = 1'b0;
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ovr_consume_count: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h11) begin errors++; $display("FAIL ovr_consume_data: got %h expected 11", got_q[0]); end
    end
    checks++; if (rx.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear: got %b expected 0", rx.rx_valid); end
  endtask

  task automatic test_back_to_back;
    int ov0;
    ready_mode = 1'b1;
    got_q.delete();
    ov0 = ov_cnt;
    send_frame(8'h0A, 1'b1, 1);
    send_frame(8'h55, 1'b1, 1);
    wait_cycles(CPB);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h0A || got_q[1] !== 8'h55) begin errors++; $display("FAIL b2b_data: got %h %h expected 0a 55", got_q[0], got_q[1]); end
    end
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL b2b_overrun: got %0d expected 0", ov_cnt - ov0); end
    ready_mode = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int exp_fe, fe0, ov0;
    ready_mode = 1'b1;
    got_q.delete();
    exp_fe = 0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send_frame(b, 1'b0, 1);
        exp_fe++;
        drive(1'b1, CPB);
      end else begin
        send_frame(b, 1'b1, 1);
        exp_q.push_back(b);
        drive(1'b1, $urandom_range(0, 3));
      end
    end
    wait_cycles(CPB);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (fe_cnt - fe0 !== exp_fe) begin errors++; $display("FAIL rand_frame_err: got %0d expected %0d", fe_cnt - fe0, exp_fe); end
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL rand_overrun: got %0d expected 0", ov_cnt - ov0); end
    ready_mode = 1'b0;
  endtask

  task automatic test_reset_mid;
    int b0, fe0;
    ready_const = 1'b1;
    got_q.delete();
    drive(1'b0, CPB);
    drive(1'b1, 3 * CPB);
    uart_rxd = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(3);
    checks++; if (rx.rx_valid !== 1'b0 || rx.rx_data !== 8'h00) begin errors++; $display("FAIL rmid_outputs: got valid=%b data=%h expected 0 00", rx.rx_valid, rx.rx_data); end
    checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rmid_flags: got busy=%b fe=%b ov=%b expected 0 0 0", busy, frame_err, overrun); end
    reset = 1'b0;
    b0 = busy_cycles; fe0 = fe_cnt;
    wait_cycles(3 * CPB);
    checks++; if (busy_cycles - b0 !== 0) begin errors++; $display("FAIL rmid_no_start: got %0d busy cycles expected 0", busy_cycles - b0); end
    checks++; if (got_q.size() !== 0 || fe_cnt - fe0 !== 0) begin errors++; $display("FAIL rmid_no_output: got bytes=%0d fe=%0d expected 0 0", got_q.size(), fe_cnt - fe0); end
    drive(1'b1, 2 * CPB);
    send_frame(8'h42, 1'b1, 1);
    wait_cycles(CPB);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rmid_fresh_count: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h42) begin errors++; $display("FAIL rmid_fresh_data: got %h expected 42", got_q[0]); end
    end
    checks++; if (rx.rx_data !== 8'h42) begin errors++; $display("FAIL rmid_rx_data: got %h expected 42", rx.rx_data); end
  endtask

  task automatic test_stability;
    checks++; if (viol !== 0) begin errors++; $display("FAIL data_stability: got %0d violations expected 0", viol); end
  endtask

  initial begin
    reset = 1'b1;
    uart_rxd = 1'b1;
    ready_mode = 1'b0;
    ready_const = 1'b0;
    test_reset;
    test_single;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_back_to_back;
    test_random;
    test_reset_mid;
    test_stability;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
